// File: rtl/regfile_mp.sv
// Multi-port CPU register file: two prioritised write ports, two combinational
// read ports with optional write bypass, hardwired zero register and busy scoreboard.
module regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              bs_set,
    input  logic [ADDR_W-1:0] bs_addr,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [ADDR_W:0]     busy_cnt_q;
    logic [ADDR_W:0]     busy_cnt_d;

    logic              we0_eff_s;
    logic              we1_eff_s;
    logic              bs_eff_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic              busy1_s;
    logic              busy2_s;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
    endfunction

    function automatic logic [DATA_W-1:0] init_val(input int idx);
        if (INIT_MODE == 1) begin
            return DATA_W'(unsigned'(idx));
        end else begin
            return {DATA_W{1'b0}};
        end
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] vec);
        logic [ADDR_W:0] cnt;
        cnt = {(ADDR_W + 1){1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + {{ADDR_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // Address 0 is invisible to writes and the scoreboard when it is hardwired.
    assign we0_eff_s = we0 && !is_zero_reg(wa0);
    assign we1_eff_s = we1 && !is_zero_reg(wa1);
    assign bs_eff_s  = bs_set && !is_zero_reg(bs_addr);

    // Register array update; the later assignment gives port 1 priority on collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= init_val(i);
            end
        end else begin
            if (we0_eff_s) begin
                regs_q[wa0] <= wd0;
            end
            if (we1_eff_s) begin
                regs_q[wa1] <= wd1;
            end
        end
    end

    // Read port 1 with zero-register override and optional bypass.
    always_comb begin
        rd1_s = regs_q[ra1];
        if (is_zero_reg(ra1)) begin
            rd1_s = {DATA_W{1'b0}};
        end else if ((BYPASS != 0) && we1_eff_s && (wa1 == ra1)) begin
            rd1_s = wd1;
        end else if ((BYPASS != 0) && we0_eff_s && (wa0 == ra1)) begin
            rd1_s = wd0;
        end else begin
            rd1_s = regs_q[ra1];
        end
    end

    // Read port 2 with zero-register override and optional bypass.
    always_comb begin
        rd2_s = regs_q[ra2];
        if (is_zero_reg(ra2)) begin
            rd2_s = {DATA_W{1'b0}};
        end else if ((BYPASS != 0) && we1_eff_s && (wa1 == ra2)) begin
            rd2_s = wd1;
        end else if ((BYPASS != 0) && we0_eff_s && (wa0 == ra2)) begin
            rd2_s = wd0;
        end else begin
            rd2_s = regs_q[ra2];
        end
    end

    // A retiring write hides busy unless a new producer issues to the same register.
    always_comb begin
        busy1_s = busy_q[ra1];
        busy2_s = busy_q[ra2];
        if ((BYPASS != 0)
            && ((we0_eff_s && (wa0 == ra1)) || (we1_eff_s && (wa1 == ra1)))
            && !(bs_eff_s && (bs_addr == ra1))) begin
            busy1_s = 1'b0;
        end else begin
            busy1_s = busy_q[ra1];
        end
        if ((BYPASS != 0)
            && ((we0_eff_s && (wa0 == ra2)) || (we1_eff_s && (wa1 == ra2)))
            && !(bs_eff_s && (bs_addr == ra2))) begin
            busy2_s = 1'b0;
        end else begin
            busy2_s = busy_q[ra2];
        end
    end

    // Scoreboard next state: set beats clear beats hold.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (bs_eff_s && (bs_addr == ADDR_W'(r))) begin
                busy_d[r] = 1'b1;
            end else if ((we0_eff_s && (wa0 == ADDR_W'(r))) || (we1_eff_s && (wa1 == ADDR_W'(r)))) begin
                busy_d[r] = 1'b0;
            end else begin
                busy_d[r] = busy_q[r];
            end
        end
        busy_cnt_d = popcount(busy_d);
    end

    // Scoreboard and busy count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= {NUM_REGS{1'b0}};
            busy_cnt_q <= {(ADDR_W + 1){1'b0}};
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign rd1      = rd1_s;
    assign rd2      = rd2_s;
    assign busy1    = busy1_s;
    assign busy2    = busy2_s;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypassing DUT and a non-bypassing DUT share stimulus.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam int S_RD1    = 0;
    localparam int S_RD2    = 1;
    localparam int S_B1     = 2;
    localparam int S_B2     = 3;
    localparam int S_CNT    = 4;
    localparam int S_RD1_NB = 5;
    localparam int S_B1_NB  = 6;
    localparam int S_RD2_NB = 7;
    localparam int S_CNT_NB = 8;
    localparam int S_B2_NB  = 9;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          we0, we1, bs_set;
    logic [AW-1:0] wa0, wa1, ra1, ra2, bs_addr;
    logic [DW-1:0] wd0, wd1;
    logic [DW-1:0] rd1, rd2, rd1_nb, rd2_nb;
    logic          busy1, busy2, busy1_nb, busy2_nb;
    logic [AW:0]   busy_cnt, busy_cnt_nb;

    exp_t exp_q[$];
    int   tests  = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1), .INIT_MODE(1)) u_dut (
        .clk(clk), .rst(rst),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .bs_set(bs_set), .bs_addr(bs_addr),
        .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0), .INIT_MODE(1)) u_nb (
        .clk(clk), .rst(rst),
        .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
        .bs_set(bs_set), .bs_addr(bs_addr),
        .busy1(busy1_nb), .busy2(busy2_nb), .busy_cnt(busy_cnt_nb)
    );

    // Monitor: on each falling edge pop every queued expectation and compare.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                S_RD1:    act = rd1;
                S_RD2:    act = rd2;
                S_B1:     act = {31'd0, busy1};
                S_B2:     act = {31'd0, busy2};
                S_CNT:    act = {26'd0, busy_cnt};
                S_RD1_NB: act = rd1_nb;
                S_B1_NB:  act = {31'd0, busy1_nb};
                S_RD2_NB: act = rd2_nb;
                S_CNT_NB: act = {26'd0, busy_cnt_nb};
                S_B2_NB:  act = {31'd0, busy2_nb};
                default:  act = 32'hxxxx_xxxx;
            endcase
            tests++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
            end
        end
    end

    task automatic expect_val(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        rst = 1'b0; we0 = 1'b0; we1 = 1'b0; bs_set = 1'b0;
        wa0 = 5'd0; wa1 = 5'd0; wd0 = 32'd0; wd1 = 32'd0;
        ra1 = 5'd0; ra2 = 5'd0; bs_addr = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();

        // Reset image
        idle(); ra1 = 5'd2; ra2 = 5'd3;
        expect_val("rst_rd1", S_RD1, 32'd2);
        expect_val("rst_rd2", S_RD2, 32'd3);
        expect_val("rst_b1", S_B1, 32'd0);
        expect_val("rst_b2", S_B2, 32'd0);
        expect_val("rst_cnt", S_CNT, 32'd0);
        expect_val("rst_rd1_nb", S_RD1_NB, 32'd2);
        step();

        // Write with same-cycle read
        idle(); we0 = 1'b1; wa0 = 5'd1; wd0 = 32'h1234_5678; ra1 = 5'd1;
        expect_val("byp_rd1", S_RD1, 32'h1234_5678);
        expect_val("nobyp_rd1_old", S_RD1_NB, 32'd1);
        step();
        idle(); ra1 = 5'd1;
        expect_val("wr_rd1", S_RD1, 32'h1234_5678);
        expect_val("nobyp_rd1_new", S_RD1_NB, 32'h1234_5678);
        step();

        // Dual-write collision
        idle(); we0 = 1'b1; we1 = 1'b1; wa0 = 5'd5; wa1 = 5'd5;
        wd0 = 32'hAAAA_0000; wd1 = 32'h5555_FFFF; ra1 = 5'd5; ra2 = 5'd5;
        expect_val("coll_byp_rd1", S_RD1, 32'h5555_FFFF);
        expect_val("coll_byp_rd2", S_RD2, 32'h5555_FFFF);
        expect_val("coll_nb_rd2_old", S_RD2_NB, 32'd5);
        step();
        idle(); ra1 = 5'd5;
        expect_val("coll_rd1", S_RD1, 32'h5555_FFFF);
        expect_val("coll_nb_rd1", S_RD1_NB, 32'h5555_FFFF);
        step();

        // Two writes to different registers, port 0 bypass path
        idle(); we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h0000_600D;
        we1 = 1'b1; wa1 = 5'd8; wd1 = 32'h0000_8888; ra1 = 5'd6; ra2 = 5'd8;
        expect_val("dual_byp_rd1", S_RD1, 32'h0000_600D);
        expect_val("dual_byp_rd2", S_RD2, 32'h0000_8888);
        step();
        idle(); ra1 = 5'd6; ra2 = 5'd8;
        expect_val("dual_rd1", S_RD1, 32'h0000_600D);
        expect_val("dual_rd2", S_RD2, 32'h0000_8888);
        step();

        // Zero register
        idle(); we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hDEAD_BEEF;
        bs_set = 1'b1; bs_addr = 5'd0; ra1 = 5'd0;
        expect_val("zero_rd1_pre", S_RD1, 32'd0);
        expect_val("zero_b1_pre", S_B1, 32'd0);
        step();
        idle(); ra1 = 5'd0;
        expect_val("zero_rd1_post", S_RD1, 32'd0);
        expect_val("zero_b1_post", S_B1, 32'd0);
        expect_val("zero_cnt", S_CNT, 32'd0);
        expect_val("zero_rd1_nb", S_RD1_NB, 32'd0);
        step();

        // Scoreboard: issue to reg7
        idle(); bs_set = 1'b1; bs_addr = 5'd7; ra1 = 5'd7;
        expect_val("sb_set_b1_pre", S_B1, 32'd0);
        step();
        idle(); ra1 = 5'd7; ra2 = 5'd7;
        expect_val("sb_set_b1", S_B1, 32'd1);
        expect_val("sb_set_cnt", S_CNT, 32'd1);
        expect_val("sb_set_cnt_nb", S_CNT_NB, 32'd1);
        expect_val("sb_set_b2_nb", S_B2_NB, 32'd1);
        step();
        // Retire and re-issue reg7 in the same cycle
        idle(); we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h0000_0077;
        bs_set = 1'b1; bs_addr = 5'd7; ra1 = 5'd7;
        expect_val("sb_reissue_b1", S_B1, 32'd1);
        expect_val("sb_reissue_rd1", S_RD1, 32'h0000_0077);
        step();
        idle(); ra1 = 5'd7;
        expect_val("sb_reissue_b1_post", S_B1, 32'd1);
        expect_val("sb_reissue_cnt", S_CNT, 32'd1);
        step();
        // Retire only
        idle(); we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h0000_0070; ra1 = 5'd7;
        expect_val("sb_retire_b1_byp", S_B1, 32'd0);
        expect_val("sb_retire_b1_nb", S_B1_NB, 32'd1);
        step();
        idle(); ra1 = 5'd7;
        expect_val("sb_retire_b1", S_B1, 32'd0);
        expect_val("sb_retire_cnt", S_CNT, 32'd0);
        expect_val("sb_retire_rd1", S_RD1, 32'h0000_0070);
        step();

        // Mid-operation reset setup: write reg3, then mark 3, 4, 9 busy (9 twice)
        idle(); we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h8765_4321;
        step();
        idle(); bs_set = 1'b1; bs_addr = 5'd3;
        step();
        idle(); bs_set = 1'b1; bs_addr = 5'd4;
        step();
        idle(); bs_set = 1'b1; bs_addr = 5'd9;
        step();
        idle(); bs_set = 1'b1; bs_addr = 5'd9;
        step();
        idle(); ra1 = 5'd3; ra2 = 5'd9;
        expect_val("pre_rst_cnt", S_CNT, 32'd3);
        expect_val("pre_rst_rd1", S_RD1, 32'h8765_4321);
        expect_val("pre_rst_b1", S_B1, 32'd1);
        expect_val("pre_rst_b2", S_B2, 32'd1);
        step();

        // Reset with a write and an issue in the same cycle
        idle(); rst = 1'b1; we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h0000_0001;
        bs_set = 1'b1; bs_addr = 5'd10;
        step();
        idle(); ra1 = 5'd3; ra2 = 5'd4;
        expect_val("midrst_cnt", S_CNT, 32'd0);
        expect_val("midrst_rd1", S_RD1, 32'd3);
        expect_val("midrst_rd2", S_RD2, 32'd4);
        expect_val("midrst_b1", S_B1, 32'd0);
        expect_val("midrst_b2", S_B2, 32'd0);
        step();
        idle(); ra1 = 5'd10; ra2 = 5'd9;
        expect_val("midrst_b10", S_B1, 32'd0);
        expect_val("midrst_b9", S_B2, 32'd0);
        expect_val("midrst_rd1_10", S_RD1, 32'd10);
        step();

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
